// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter and its
// round-robin picker: default widths, the write-request record and the
// wrapped index helper used by the rotating priority search.
package regfile_pkg;

  localparam int REGSIZE_DEF = 5;
  localparam int DIGIT_DEF   = 32;

  // One write request as it travels to the register file.
  typedef struct packed {
    logic [REGSIZE_DEF-1:0] addr;
    logic [DIGIT_DEF-1:0]   data;
  } wr_req_t;

  // Index reached by stepping 'offset' places past 'ptr' in a ring of 'n'.
  function automatic int unsigned rr_index(input int unsigned ptr,
                                           input int unsigned offset,
                                           input int unsigned n);
    return (ptr + offset) % n;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus between the writeback requesters and the write-port arbiter.
// Handshake: requester i raises Req_Valid[i] with Req_Address/Req_Data
// held stable; a transfer happens on the rising clock edge where
// Req_Valid[i] && Req_Ready[i]. Req_Ready is at most one-hot, and the
// requester may drop Req_Valid before Ready to withdraw the request.
// The Write_* group drives the register file one cycle after a transfer.
interface regfile_write_arbiter_if #(
  parameter int REQUESTERS = 3,
  parameter int REGSIZE    = 5,
  parameter int DIGIT      = 32
);
  localparam int IDXW = $clog2(REQUESTERS);

  logic                          Flush;
  logic [REQUESTERS-1:0]         Req_Valid;
  logic [REQUESTERS*REGSIZE-1:0] Req_Address;
  logic [REQUESTERS*DIGIT-1:0]   Req_Data;
  logic [REQUESTERS-1:0]         Req_Ready;
  logic [REGSIZE-1:0]            Write_Address;
  logic [DIGIT-1:0]              Write_Data;
  logic                          Write_Enable;
  logic [IDXW-1:0]               Grant_Index;
  logic                          Conflict;

  // Requester / environment side.
  modport master (
    output Flush, Req_Valid, Req_Address, Req_Data,
    input  Req_Ready, Write_Address, Write_Data, Write_Enable,
           Grant_Index, Conflict
  );

  // Arbiter side.
  modport slave (
    input  Flush, Req_Valid, Req_Address, Req_Data,
    output Req_Ready, Write_Address, Write_Data, Write_Enable,
           Grant_Index, Conflict
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches the request vector starting
// one place after the pointer, wrapping, and returns a one-hot grant plus
// its encoded index. Holds no state so a read-port arbiter can reuse it.
module rr_pick
  import regfile_pkg::*;
#(
  parameter int N    = 3,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [IDXW-1:0] o_idx,
  output logic            o_valid
);

  int unsigned w_cand;

  // First requester found after the pointer wins; later hits are ignored.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    for (int k = 1; k <= N; k++) begin
      w_cand = rr_index(32'(i_ptr), k, N);
      if (!o_valid && i_req[w_cand[IDXW-1:0]]) begin
        o_grant[w_cand[IDXW-1:0]] = 1'b1;
        o_idx                     = w_cand[IDXW-1:0];
        o_valid                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among REQUESTERS writeback
// sources. A round-robin grant is issued combinationally; the granted
// request is captured into an output stage that drives the register file
// one cycle later. Writes to register 0 are consumed without enabling.
// Flush squashes the current grant and clears the output enable.
// Optional build macro REGFILE_ARB_FIXED_PRIO_EN: requester 0 always wins,
// and the other requesters rotate among themselves (the pointer only
// moves on grants to requesters 1..N-1).
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int REGSIZE    = REGSIZE_DEF,
  parameter int DIGIT      = DIGIT_DEF,
  parameter int REQUESTERS = 3
) (
  input  logic clock,
  input  logic reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int IDXW = $clog2(REQUESTERS);
  localparam logic [IDXW-1:0] PTR_RESET = IDXW'(REQUESTERS - 1);

  logic [IDXW-1:0]       r_ptr;
  logic                  r_we;
  logic [REGSIZE-1:0]    r_addr;
  logic [DIGIT-1:0]      r_data;
  logic [IDXW-1:0]       r_gidx;

  logic [REQUESTERS-1:0] w_rr_req;
  logic [REQUESTERS-1:0] w_rr_grant;
  logic [IDXW-1:0]       w_rr_idx;
  logic                  w_rr_valid;

  logic [REQUESTERS-1:0] w_grant;
  logic [IDXW-1:0]       w_idx;
  logic                  w_any;
  logic                  w_xfer;
  logic                  w_ptr_upd;
  logic [REGSIZE-1:0]    w_sel_addr;
  logic [DIGIT-1:0]      w_sel_data;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  // Requester 0 is handled outside the ring; the ring only sees 1..N-1.
  assign w_rr_req  = bus.Req_Valid & ~REQUESTERS'(1);
  assign w_grant   = bus.Req_Valid[0] ? REQUESTERS'(1) : w_rr_grant;
  assign w_idx     = bus.Req_Valid[0] ? '0 : w_rr_idx;
  assign w_any     = bus.Req_Valid[0] | w_rr_valid;
  assign w_ptr_upd = !bus.Req_Valid[0];
`else
  assign w_rr_req  = bus.Req_Valid;
  assign w_grant   = w_rr_grant;
  assign w_idx     = w_rr_idx;
  assign w_any     = w_rr_valid;
  assign w_ptr_upd = 1'b1;
`endif

  rr_pick #(
    .N    (REQUESTERS),
    .IDXW (IDXW)
  ) u_rr_pick (
    .i_req   (w_rr_req),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_valid (w_rr_valid)
  );

  // Flush blocks the grant, so nothing transfers on a flushed edge.
  assign bus.Req_Ready = bus.Flush ? '0 : w_grant;
  assign w_xfer        = w_any && !bus.Flush;

  // Steer the granted requester's address and data toward the output stage.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = bus.Req_Address[i*REGSIZE +: REGSIZE];
        w_sel_data = bus.Req_Data[i*DIGIT +: DIGIT];
      end
    end
  end

  // Output stage and last-grant pointer; reset discards any staged write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr  <= PTR_RESET;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_gidx <= '0;
    end else if (w_xfer) begin
      r_addr <= w_sel_addr;
      r_data <= w_sel_data;
      r_gidx <= w_idx;
      r_we   <= (w_sel_addr != '0);
      if (w_ptr_upd) begin
        r_ptr <= w_idx;
      end
    end else begin
      r_we <= 1'b0;
    end
  end

  assign bus.Write_Address = r_addr;
  assign bus.Write_Data    = r_data;
  assign bus.Write_Enable  = r_we;
  assign bus.Grant_Index   = r_gidx;
  assign bus.Conflict      = ($countones(bus.Req_Valid) > 1);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference of the arbiter.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int W  = $bits(wr_req_t);

  logic clock;
  logic reset;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state.
  int          m_ptr;
  logic        m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int          m_gidx;
  int          last_g;
  logic [W-1:0] exp_q[$];

  regfile_write_arbiter_if #(.REQUESTERS(N), .REGSIZE(AW), .DIGIT(DW)) bus ();

  regfile_write_arbiter #(
    .REGSIZE    (AW),
    .DIGIT      (DW),
    .REQUESTERS (N)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference arbitration: walk the ring from the requester after the last
  // grant; with fixed priority, requester 0 wins outright and is skipped in
  // the ring.
  function automatic int model_pick(input logic [N-1:0] v, input logic fl, input int ptr);
    if (fl) return -1;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (ptr + k) % N;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      if (c == 0) continue;
`endif
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr  = N - 1;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_gidx = 0;
    exp_q.delete();
  endtask

  // Driver tasks.
  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.Req_Valid[i]           = v;
    bus.Req_Address[i*AW +: AW] = a;
    bus.Req_Data[i*DW +: DW]    = d;
  endtask

  task automatic clear_reqs();
    bus.Req_Valid   = '0;
    bus.Req_Address = '0;
    bus.Req_Data    = '0;
    bus.Flush       = 1'b0;
  endtask

  // One cycle: check grant/conflict with stable inputs, advance the model,
  // cross the edge and check the output stage plus the write scoreboard.
  task automatic step();
    int g;
    logic [N-1:0] exp_rdy;
    wr_req_t e;
    #1;
    g = model_pick(bus.Req_Valid, bus.Flush, m_ptr);
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", bus.Req_Ready, exp_rdy);
    check("conflict", bus.Conflict, ($countones(bus.Req_Valid) >= 2));
    last_g = g;
    if (g >= 0) begin
      m_addr = bus.Req_Address[g*AW +: AW];
      m_data = bus.Req_Data[g*DW +: DW];
      m_gidx = g;
      m_we   = (m_addr != 0);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      if (g != 0) m_ptr = g;
`else
      m_ptr = g;
`endif
      if (m_we) begin
        e.addr = m_addr;
        e.data = m_data;
        exp_q.push_back(e);
      end
    end else begin
      m_we = 1'b0;
    end
    @(posedge clock);
    #1;
    check("write_enable", bus.Write_Enable, m_we);
    check("write_address", bus.Write_Address, m_addr);
    check("write_data", bus.Write_Data, m_data);
    check("grant_index", bus.Grant_Index, m_gidx);
    if (bus.Write_Enable) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", bus.Write_Enable, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sb_write", {bus.Write_Address, bus.Write_Data}, e);
      end
    end
  endtask

  logic [N-1:0]  pv;
  logic [AW-1:0] pa [N];
  logic [DW-1:0] pd [N];

  initial begin
    reset = 1'b0;
    clear_reqs();
    model_reset();
    last_g = -1;
    #12;
    check("rst_we", bus.Write_Enable, 1'b0);
    check("rst_addr", bus.Write_Address, '0);
    check("rst_data", bus.Write_Data, '0);
    check("rst_gidx", bus.Grant_Index, '0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Round robin: all three valid with addresses 1,2,3 for six cycles.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), $urandom);
      step();
    end
    check("rr_tail_conflict", bus.Conflict, 1'b1);

    // Zero register: consumed, never enabled.
    clear_reqs();
    set_req(1, 1'b1, '0, 32'hDEADBEEF);
    step();
    check("zero_we", bus.Write_Enable, 1'b0);

    // Flush collision, then the same request goes through.
    clear_reqs();
    set_req(2, 1'b1, 5'd7, 32'h0000_1234);
    bus.Flush = 1'b1;
    step();
    bus.Flush = 1'b0;
    step();
    clear_reqs();
    step();

    // Withdraw: requester 2 valid alongside 0 for one cycle, then drops.
    set_req(0, 1'b1, 5'd4, 32'h0000_0A0A);
    set_req(2, 1'b1, 5'd9, 32'h0000_0909);
    step();
    clear_reqs();
    step();
    step();

    // Mid-operation reset with a staged write on the outputs.
    set_req(0, 1'b1, 5'd5, 32'h5555_AAAA);
    step();
    clear_reqs();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("midrst_we", bus.Write_Enable, 1'b0);
    check("midrst_gidx", bus.Grant_Index, '0);
    check("midrst_addr", bus.Write_Address, '0);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 10), $urandom);
    step();
    clear_reqs();

    // Random traffic that honours the hold-until-ready rule.
    pv = '0;
    for (int i = 0; i < N; i++) begin
      pa[i] = '0;
      pd[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pv[i] = 1'b1;
            pa[i] = AW'($urandom_range(0, 31));
            pd[i] = $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pv[i] = 1'b0;
        end
        set_req(i, pv[i], pa[i], pd[i]);
      end
      bus.Flush = ($urandom_range(0, 9) == 0);
      step();
      if (last_g >= 0) pv[last_g] = 1'b0;
    end
    clear_reqs();
    step();
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
